// File: rtl/timer_ctrl_regs.sv
// CPU control/status registers in front of the timer FSM.
// Optional overrun flag: define TIMER_OVERRUN_EN.
module timer_ctrl_regs #(
    parameter int         PER_W  = 4,
    parameter int         DATA_W = 8,
    parameter logic [7:0] ID_VAL = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_cs,
    input  logic              bus_we,
    input  logic [1:0]        bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_ack,
    output logic              fsm_start,
    output logic [PER_W-1:0]  period_out,
    input  logic              fsm_we,
    input  logic              fsm_end,
    output logic              irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              ctrl_ie;
    logic              ctrl_auto;
    logic [PER_W-1:0]  period_r;
    logic              done_f;
    logic              err_f;
    logic              ovr_f;
    logic [3:0]        dcnt;
    logic              abort_pend;
    logic              abort_set;
    logic              start_ok;
    logic              start_rej;
    logic              reload;
    logic              reload_err;
    logic              irq_src;
    logic [DATA_W-1:0] rd_mux;

    logic wr;
    logic wr_ctrl;
    logic wr_per;
    logic wr_stat;
    logic wr_abort;
    logic fsm_hit;
    logic busy;
    logic per_zero;

    assign wr        = bus_cs & bus_we;
    assign wr_ctrl   = wr & (bus_addr == 2'd0);
    assign wr_per    = wr & (bus_addr == 2'd1);
    assign wr_stat   = wr & (bus_addr == 2'd2);
    assign wr_abort  = wr_ctrl & ~bus_wdata[0];
    assign fsm_hit   = fsm_we & fsm_end;
    assign busy      = (state != S_IDLE);
    assign per_zero  = (period_r == '0);
    assign fsm_start = (state == S_ARMED);

    // Next-state decode and the one-shot events it produces
    always_comb begin
        state_nx   = state;
        start_ok   = 1'b0;
        start_rej  = 1'b0;
        reload     = 1'b0;
        reload_err = 1'b0;
        abort_set  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (wr_ctrl && bus_wdata[0]) begin
                    if (!per_zero) begin
                        state_nx = S_ARMED;
                        start_ok = 1'b1;
                    end else begin
                        start_rej = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (fsm_hit) begin
                    state_nx  = S_DONE;
                    abort_set = wr_abort;
                end else if (wr_abort) begin
                    state_nx = S_IDLE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                if (ctrl_auto && !abort_pend && !wr_abort) begin
                    if (!per_zero) begin
                        state_nx = S_ARMED;
                        reload   = 1'b1;
                    end else begin
                        reload_err = 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register; an abort racing a completion is remembered for DONE
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            abort_pend <= 1'b0;
        end else begin
            state      <= state_nx;
            abort_pend <= abort_set;
        end
    end

    // Control, period and status flags; hardware set beats CPU clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_ie    <= 1'b0;
            ctrl_auto  <= 1'b0;
            period_r   <= '0;
            period_out <= '0;
            done_f     <= 1'b0;
            err_f      <= 1'b0;
            dcnt       <= 4'd0;
        end else begin
            if (wr_ctrl) begin
                ctrl_ie   <= bus_wdata[1];
                ctrl_auto <= bus_wdata[2];
            end
            if (wr_per)
                period_r <= bus_wdata[PER_W-1:0];
            if (start_ok || reload)
                period_out <= period_r;
            if (start_rej || reload_err)
                err_f <= 1'b1;
            else if (start_ok || (wr_stat && bus_wdata[3]))
                err_f <= 1'b0;
            if (state == S_DONE)
                done_f <= 1'b1;
            else if (wr_stat && bus_wdata[0])
                done_f <= 1'b0;
            if (state == S_DONE) begin
                if (wr_stat && bus_wdata[7])
                    dcnt <= 4'd1;
                else if (dcnt != 4'hF)
                    dcnt <= dcnt + 4'd1;
            end else if (wr_stat && bus_wdata[7]) begin
                dcnt <= 4'd0;
            end
        end
    end

`ifdef TIMER_OVERRUN_EN
    // Overrun: a completion lands while the previous one is unacknowledged
    always_ff @(posedge clk) begin
        if (!rst)
            ovr_f <= 1'b0;
        else if (state == S_DONE && done_f)
            ovr_f <= 1'b1;
        else if (wr_stat && bus_wdata[2])
            ovr_f <= 1'b0;
    end
    assign irq_src = ctrl_ie & (done_f | ovr_f);
`else
    assign ovr_f   = 1'b0;
    assign irq_src = ctrl_ie & done_f;
`endif

    // Level interrupt, registered from the current flags
    always_ff @(posedge clk) begin
        if (!rst)
            irq <= 1'b0;
        else
            irq <= irq_src;
    end

    // Read mux over pre-update register values
    always_comb begin
        rd_mux = '0;
        case (bus_addr)
            2'd0: rd_mux[2:0] = {ctrl_auto, ctrl_ie, busy};
            2'd1: rd_mux[PER_W-1:0] = period_r;
            2'd2: rd_mux[7:0] = {dcnt, err_f, ovr_f, busy, done_f};
            default: rd_mux[7:0] = ID_VAL;
        endcase
    end

    // One-cycle ack; read data only on read acks, zero otherwise
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_ack   <= bus_cs;
            bus_rdata <= (bus_cs && !bus_we) ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_timer_ctrl_regs.sv
// Directed self-checking bench for timer_ctrl_regs.
// Define TIMER_OVERRUN_EN for both files to test the overrun flag.
module tb_timer_ctrl_regs;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bus_cs = 1'b0;
    logic       bus_we = 1'b0;
    logic [1:0] bus_addr = 2'd0;
    logic [7:0] bus_wdata = 8'd0;
    logic [7:0] bus_rdata;
    logic       bus_ack;
    logic       fsm_start;
    logic [3:0] period_out;
    logic       fsm_we = 1'b0;
    logic       fsm_end = 1'b0;
    logic       irq;

    int checks = 0;
    int errors = 0;

`ifdef TIMER_OVERRUN_EN
    localparam logic [7:0] OVR = 8'h04;
`else
    localparam logic [7:0] OVR = 8'h00;
`endif

    timer_ctrl_regs #(
        .PER_W (4),
        .DATA_W(8),
        .ID_VAL(8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_cs    (bus_cs),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .fsm_start (fsm_start),
        .period_out(period_out),
        .fsm_we    (fsm_we),
        .fsm_end   (fsm_end),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_cs = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(negedge clk);
        bus_cs = 1'b0; bus_we = 1'b0;
        chk("wr_ack", bus_ack, 1);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a,
                          input logic [7:0] exp);
        @(negedge clk);
        bus_cs = 1'b1; bus_we = 1'b0; bus_addr = a;
        chk("rd_ack_pre", bus_ack, 0);
        @(negedge clk);
        bus_cs = 1'b0;
        chk("rd_ack", bus_ack, 1);
        chk(tag, bus_rdata, exp);
    endtask

    // Drive one end-of-count pulse from the current negedge
    task automatic pulse_fsm();
        fsm_we = 1'b1; fsm_end = 1'b1;
        @(negedge clk);
        fsm_we = 1'b0; fsm_end = 1'b0;
    endtask

    // Completion in auto mode: back in ARMED after the DONE cycle
    task automatic complete();
        pulse_fsm();
        @(negedge clk);
    endtask

    initial begin
        // reset with random bus traffic
        repeat (3) begin
            bus_cs    = 1'($urandom_range(0, 1));
            bus_we    = 1'($urandom_range(0, 1));
            bus_addr  = 2'($urandom_range(0, 3));
            bus_wdata = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        chk("rst_ack", bus_ack, 0);
        chk("rst_rdata", bus_rdata, 0);
        chk("rst_start", fsm_start, 0);
        chk("rst_period", period_out, 0);
        chk("rst_irq", irq, 0);
        bus_cs = 1'b0; bus_we = 1'b0; rst = 1'b1;

        rd_chk("id", 2'd3, 8'hA5);
        @(negedge clk);
        chk("rdata_idle", bus_rdata, 0);
        rd_chk("ctrl0", 2'd0, 8'h00);
        rd_chk("stat0", 2'd2, 8'h00);

        // one-shot with interrupt
        bus_wr(2'd1, 8'h05);
        bus_wr(2'd0, 8'h03);
        chk("os_start", fsm_start, 1);
        chk("os_period", period_out, 5);
        pulse_fsm();
        chk("os_start_drop", fsm_start, 0);
        repeat (2) @(negedge clk);
        chk("os_irq", irq, 1);
        rd_chk("os_stat", 2'd2, 8'h11);
        rd_chk("os_ctrl", 2'd0, 8'h02);
        bus_wr(2'd2, 8'h01);
        @(negedge clk);
        chk("os_irq_clr", irq, 0);
        rd_chk("os_stat2", 2'd2, 8'h10);

        // zero period rejected
        bus_wr(2'd1, 8'h00);
        bus_wr(2'd0, 8'h01);
        chk("rej_start", fsm_start, 0);
        rd_chk("rej_stat", 2'd2, 8'h18);
        rd_chk("rej_ctrl", 2'd0, 8'h00);
        bus_wr(2'd2, 8'h88);
        rd_chk("rej_clr", 2'd2, 8'h00);

        // auto-reload, period update while armed, DCNT saturation
        bus_wr(2'd1, 8'h03);
        bus_wr(2'd0, 8'h05);
        chk("ar_period3", period_out, 3);
        chk("ar_start", fsm_start, 1);
        bus_wr(2'd1, 8'h07);
        chk("ar_hold3", period_out, 3);
        rd_chk("ar_perreg", 2'd1, 8'h07);
        complete();
        chk("ar_period7", period_out, 7);
        chk("ar_rearm", fsm_start, 1);
        repeat (3) complete();
        rd_chk("ar_dcnt4", 2'd2, 8'h43 | OVR);
        repeat (16) complete();
        rd_chk("ar_dcnt15", 2'd2, 8'hF3 | OVR);
        rd_chk("ar_ctrl", 2'd0, 8'h05);
        chk("ar_irq_off", irq, 0);

        // abort, then stray completion ignored
        bus_wr(2'd0, 8'h00);
        chk("ab_start", fsm_start, 0);
        bus_wr(2'd2, 8'h8D);
        rd_chk("ab_clr", 2'd2, 8'h00);
        pulse_fsm();
        repeat (2) @(negedge clk);
        rd_chk("ab_ignore", 2'd2, 8'h00);
        chk("ab_period", period_out, 7);

        // abort in the same cycle as completion
        bus_wr(2'd1, 8'h02);
        bus_wr(2'd0, 8'h05);
        chk("sa_start", fsm_start, 1);
        chk("sa_period", period_out, 2);
        bus_cs = 1'b1; bus_we = 1'b1; bus_addr = 2'd0; bus_wdata = 8'h04;
        fsm_we = 1'b1; fsm_end = 1'b1;
        @(negedge clk);
        bus_cs = 1'b0; bus_we = 1'b0; fsm_we = 1'b0; fsm_end = 1'b0;
        chk("sa_ack", bus_ack, 1);
        chk("sa_done_st", fsm_start, 0);
        @(negedge clk);
        chk("sa_idle", fsm_start, 0);
        rd_chk("sa_stat", 2'd2, 8'h11);
        rd_chk("sa_ctrl", 2'd0, 8'h04);

        // DONE set beats same-cycle write-1-clear
        bus_wr(2'd0, 8'h01);
        chk("sw_start", fsm_start, 1);
        fsm_we = 1'b1; fsm_end = 1'b1;
        @(negedge clk);
        fsm_we = 1'b0; fsm_end = 1'b0;
        bus_cs = 1'b1; bus_we = 1'b1; bus_addr = 2'd2; bus_wdata = 8'h01;
        @(negedge clk);
        bus_cs = 1'b0; bus_we = 1'b0;
        chk("sw_ack", bus_ack, 1);
        rd_chk("sw_stat", 2'd2, 8'h21 | OVR);
`ifdef TIMER_OVERRUN_EN
        bus_wr(2'd2, 8'h04);
        rd_chk("ovr_clr", 2'd2, 8'h21);
`endif

        // reset mid-operation
        bus_wr(2'd0, 8'h03);
        chk("mr_start", fsm_start, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("mr_start0", fsm_start, 0);
        chk("mr_period0", period_out, 0);
        chk("mr_irq0", irq, 0);
        rst = 1'b1;
        rd_chk("mr_stat", 2'd2, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_ctrl_regs.md
Name: timer_ctrl_regs

Overview:
- CPU-facing control/status register block sitting directly upstream of the timer FSM.
- Holds the programmed period and start request, and drives the FSM's start input and period input.
- Consumes the FSM's end-of-count write-enable/end pulse to set a DONE flag and count completions.
- Raises a level interrupt and supports optional auto-reload (periodic mode).

Parameters:
- PER_W, 4, width of period field and of period_out.
- DATA_W, 8, bus data width; must be ≥ 8.
- ID_VAL, 8'hA5, constant returned at address 3.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset (rst=0 resets at clk edge)
- bus_cs  in  1  bus select, one-cycle request
- bus_we  in  1  1=write, 0=read, qualified by bus_cs
- bus_addr  in  2  register address
- bus_wdata  in  DATA_W  write data
- bus_rdata  out  DATA_W  read data, valid when bus_ack=1
- bus_ack  out  1  one-cycle acknowledge
- fsm_start  out  1  start request to timer FSM
- period_out  out  PER_W  period to timer FSM
- fsm_we  in  1  end-of-count write-enable from timer FSM
- fsm_end  in  1  end-of-count flag from timer FSM
- irq  out  1  interrupt, level

Behaviour:
- Reset values: all outputs 0; CTRL=0; PERIOD=0; STATUS=0; state=IDLE; period_out=0.
- Register map:
  - 0 CTRL: bit0 START (reads 1 while state≠IDLE), bit1 IE, bit2 AUTO.
  - 1 PERIOD: [PER_W-1:0].
  - 2 STATUS: bit0 DONE (write-1-clear), bit1 BUSY (RO, =state≠IDLE), bit2 OVR (see optional feature), bit3 ERR (write-1-clear), [7:4] DCNT (RO, write bit7=1 clears).
  - 3 ID: RO, ID_VAL.
  - Unused bits read 0.
- Bus timing:
  - bus_cs sampled at edge N; bus_ack=1 and bus_rdata registered during cycle N+1.
  - Writes take effect at edge N. A read returns the register value prior to the edge-N update.
  - Back-to-back requests are allowed, one per cycle.
  - bus_rdata=0 when bus_ack=0.
- Start acceptance:
  - A CTRL write with START=1 in IDLE, with PERIOD≠0, latches period_out←PERIOD, clears ERR, and moves to ARMED.
  - If PERIOD=0, the start is rejected: ERR←1 and the state stays IDLE.
  - START=1 written while not IDLE is ignored; IE/AUTO still update.
- State machine (Moore; fsm_start = state==ARMED):
  - IDLE: wait for start acceptance.
  - ARMED: on fsm_we&fsm_end → DONE. A CTRL write with START=0 → IDLE (abort).
  - DONE: one cycle. DONE flag←1; DCNT←DCNT+1, saturating at 15. Next state is ARMED if AUTO=1 (period_out re-latched from PERIOD; if PERIOD=0 go to IDLE and set ERR), else IDLE.
- fsm_start deasserts on the edge that samples fsm_we, so the downstream FSM returning to wait never sees a stale start.
- PERIOD writes while ARMED update the register only; period_out is stable until the next arm.
- fsm_we/fsm_end while IDLE (e.g. after an abort) are ignored: no DONE, no DCNT change.
- Simultaneous hardware DONE set and CPU write-1-clear of DONE in the same cycle: set wins.
- Simultaneous abort write and fsm_we in ARMED: completion wins (→DONE); START=0 takes effect as AUTO-independent return to IDLE after DONE.
- irq is registered: irq = DONE & IE, updated every cycle. It clears the cycle after DONE is cleared or IE is written 0.
- Reset mid-operation: everything returns to reset values within one edge; fsm_start=0 the next cycle.

Optional Feature:
- Macro: TIMER_OVERRUN_EN.
- Defined: OVR (STATUS bit2) sets when the DONE state is entered while DONE flag is already 1; cleared by write-1 to bit2; irq = DONE & IE | OVR & IE.
- Not defined: OVR reads 0, writes ignored, irq uses DONE only.

Test Plan:
- Reset: hold rst=0 3 cycles with random bus traffic → all outputs 0; read ID → 0xA5, ack one cycle later.
- Write PERIOD=5, write CTRL=0x03 → fsm_start=1, period_out=5. Pulse fsm_we=fsm_end=1 one cycle → fsm_start=0 next cycle, STATUS=0x11, irq=1. Write STATUS=0x01 → irq=0.
- PERIOD=0, CTRL=0x01 → state IDLE, STATUS.ERR=1, fsm_start stays 0.
- AUTO=1, PERIOD=3, start; write PERIOD=7 while armed → period_out stays 3 until the first completion, then 7. Four completions → DCNT=4; 20 completions → DCNT=15.
- Abort: armed, write CTRL=0x00 → fsm_start=0. Later fsm_we pulse → DONE stays 0, DCNT unchanged.
- With TIMER_OVERRUN_EN: two completions without clearing DONE → OVR=1. Same-cycle fsm_we and DONE write-1-clear → DONE remains 1.
